// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through no-write-allocate data cache controller
// Refills whole 4-word lines on read misses; stores always go straight to memory.
module dcache_controller #(
  parameter int INDEX_BITS  = 5,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = 32 - INDEX_BITS - OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t                r_state;
  logic [OFF_W-1:0]      r_cnt;
  logic [LINES-1:0]      r_valid;
  logic                  r_refill_done;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic [CNT_W-1:0]      r_miss_cnt;
  logic [TAG_W-1:0]      r_tag  [0:LINES-1];
  logic [31:0]           r_data [0:LINES*BLOCK_WORDS-1];

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [OFF_W-1:0]      w_off;
  logic                  w_hit;
  logic                  w_last_word;
  logic                  w_unused;

  assign w_tag       = cpu_addr[31:INDEX_BITS+OFF_W+2];
  assign w_index     = cpu_addr[INDEX_BITS+OFF_W+1:OFF_W+2];
  assign w_off       = cpu_addr[OFF_W+1:2];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last_word = (r_cnt == OFF_W'(BLOCK_WORDS - 1));
  assign w_unused    = &{1'b0, cpu_addr[1:0]};

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  // Memory-side outputs follow the state so they hold steady until the ack.
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    cpu_rdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (cpu_wr) begin
          stall = 1'b1;
        end else if (cpu_rd) begin
          if (w_hit) cpu_rdata = r_data[{w_index, w_off}];
          else       stall     = 1'b1;
        end
      end
      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_index, r_cnt, 2'b00};
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[31:2], 2'b00};
        mem_wdata = cpu_wdata;
        stall     = ~mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_valid       <= '0;
      r_refill_done <= 1'b0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_refill_done <= 1'b0;
          if (cpu_wr) begin
            r_state <= S_WRITE;
          end else if (cpu_rd) begin
            if (w_hit) begin
              // The access that finishes a refill is not a genuine hit.
              if (!r_refill_done) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
              r_miss_cnt       <= r_miss_cnt + 1'b1;
              r_valid[w_index] <= 1'b0;
              r_cnt            <= '0;
              r_state          <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_word) begin
              r_valid[w_index] <= 1'b1;
              r_refill_done    <= 1'b1;
              r_state          <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_ack) begin
      r_data[{w_index, r_cnt}] <= mem_rdata;
      if (w_last_word) r_tag[w_index] <= w_tag;
    end
    if (r_state == S_WRITE && mem_ack && w_hit) begin
      r_data[{w_index, w_off}] <= cpu_wdata;
    end
  end

endmodule
